// File: rtl/iterative_alu.sv
// rtl/iterative_alu.sv - execute-stage ALU with iterative shift-add multiply-accumulate
//
// Single-cycle operations register their result one edge after an accepted
// start. MULA runs a WIDTH-iteration shift-add multiplier. The product is
// added to a persistent accumulator, and busy holds high for the duration.
//
// Ports:
//   CLK      clock, rising edge
//   Reset_L  asynchronous active-low reset
//   start    operation request, accepted only while busy=0
//   ALUCtrl  4-bit operation code
//   BusA     operand A
//   BusB     operand B
//   acc_clr  clear accumulator (idle only)
//   BusW     registered result
//   Zero     registered, BusW==0
//   busy     MULA in progress
//   done     one-cycle pulse when BusW/Zero update
module iterative_alu #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             CLK,
    input  logic             Reset_L,
    input  logic             start,
    input  logic [3:0]       ALUCtrl,
    input  logic [WIDTH-1:0] BusA,
    input  logic [WIDTH-1:0] BusB,
    input  logic             acc_clr,
    output logic [WIDTH-1:0] BusW,
    output logic             Zero,
    output logic             busy,
    output logic             done
);

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SLL  = 4'd3;
    localparam logic [3:0] OP_SRL  = 4'd4;
    localparam logic [3:0] OP_MULA = 4'd5;
    localparam logic [3:0] OP_SUB  = 4'd6;
    localparam logic [3:0] OP_SLT  = 4'd7;
    localparam logic [3:0] OP_ADDU = 4'd8;
    localparam logic [3:0] OP_SUBU = 4'd9;
    localparam logic [3:0] OP_XOR  = 4'd10;
    localparam logic [3:0] OP_SLTU = 4'd11;
    localparam logic [3:0] OP_NOR  = 4'd12;
    localparam logic [3:0] OP_SRA  = 4'd13;
    localparam logic [3:0] OP_LUI  = 4'd14;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   partial;
    logic [WIDTH-1:0]   acc;
    logic [CNT_W-1:0]   cnt;

    logic [WIDTH-1:0]   alu_res;
    logic [CNT_W-1:0]   shamt;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH-1:0]   partial_next;
    logic [WIDTH-1:0]   mac_res;

    assign shamt = BusA[CNT_W-1:0];

    // Single-cycle results are computed straight from the inputs. The value is
    // registered on the accepting edge, so that edge is the operand capture.
    always_comb begin
        alu_res = '0;
        case (ALUCtrl)
            OP_AND:          alu_res = BusA & BusB;
            OP_OR:           alu_res = BusA | BusB;
            OP_XOR:          alu_res = BusA ^ BusB;
            OP_NOR:          alu_res = ~(BusA | BusB);
            OP_ADD, OP_ADDU: alu_res = BusA + BusB;
            OP_SUB, OP_SUBU: alu_res = BusA - BusB;
            OP_SLT:          alu_res = {{(WIDTH-1){1'b0}}, ($signed(BusA) < $signed(BusB))};
            OP_SLTU:         alu_res = {{(WIDTH-1){1'b0}}, (BusA < BusB)};
            OP_SLL:          alu_res = BusB << shamt;
            OP_SRL:          alu_res = BusB >> shamt;
            OP_SRA:          alu_res = WIDTH'($signed(BusB) >>> shamt);
            OP_LUI:          alu_res = BusB << 16;
            default:         alu_res = '0;
        endcase
    end

    // The final iteration's add is folded into the accumulate, so the
    // finishing edge can retire directly into BusW and acc.
    assign addend       = mplier[0] ? mcand : '0;
    assign partial_next = partial + addend;
    assign mac_res      = acc + partial_next;

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            state   <= IDLE;
            BusW    <= '0;
            Zero    <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            acc     <= '0;
            cnt     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            partial <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // A MULA start in the same cycle sees the cleared value,
                    // because the accumulate happens only at the end of MUL.
                    if (acc_clr) begin
                        acc <= '0;
                    end
                    if (start) begin
                        if (ALUCtrl == OP_MULA) begin
                            mcand   <= BusA;
                            mplier  <= BusB;
                            partial <= '0;
                            cnt     <= '0;
                            busy    <= 1'b1;
                            state   <= MUL;
                        end else begin
                            BusW <= alu_res;
                            Zero <= (alu_res == '0);
                            done <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    if (cnt == LAST_ITER) begin
                        BusW  <= mac_res;
                        Zero  <= (mac_res == '0);
                        acc   <= mac_res;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        partial <= partial_next;
                        mcand   <= mcand << 1;
                        mplier  <= mplier >> 1;
                        cnt     <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iterative_alu.sv
// tb/tb_iterative_alu.sv - self-checking bench for iterative_alu
module tb_iterative_alu;

    logic        CLK;
    logic        Reset_L;
    logic        start;
    logic [3:0]  ALUCtrl;
    logic [31:0] BusA;
    logic [31:0] BusB;
    logic        acc_clr;
    logic [31:0] BusW;
    logic        Zero;
    logic        busy;
    logic        done;

    int          checks;
    int          fails;
    logic [31:0] acc_m;
    logic [31:0] last_w;

    iterative_alu #(.WIDTH(32), .CNT_W(5)) dut (
        .CLK     (CLK),
        .Reset_L (Reset_L),
        .start   (start),
        .ALUCtrl (ALUCtrl),
        .BusA    (BusA),
        .BusB    (BusB),
        .acc_clr (acc_clr),
        .BusW    (BusW),
        .Zero    (Zero),
        .busy    (busy),
        .done    (done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] ref_op(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] wide;
        int unsigned sh;
        sh = a % 32;
        case (code)
            4'd0:       return a & b;
            4'd1:       return a | b;
            4'd10:      return a ^ b;
            4'd12:      return ~(a | b);
            4'd2, 4'd8: return 32'(64'(a) + 64'(b));
            4'd6, 4'd9: return 32'(64'(a) + 64'(~b) + 64'd1);
            4'd7: begin
                if (a[31] != b[31]) return {31'd0, a[31]};
                return {31'd0, a < b};
            end
            4'd11:      return {31'd0, a < b};
            4'd3: begin
                wide = 64'(b) * (64'd1 << sh);
                return wide[31:0];
            end
            4'd4:       return b / (32'd1 << sh);
            4'd13: begin
                wide = {{32{b[31]}}, b} >> sh;
                return wide[31:0];
            end
            4'd14:      return b * 32'd65536;
            default:    return 32'd0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One single-cycle op: start over one edge, result and done checked after it.
    task automatic sop(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] e;
        e = ref_op(code, a, b);
        @(negedge CLK);
        start = 1'b1; ALUCtrl = code; BusA = a; BusB = b;
        @(posedge CLK); #1;
        start = 1'b0;
        BusA = $urandom; BusB = $urandom;
        chk($sformatf("op%0d_done", code), {31'd0, done}, 32'd1);
        chk($sformatf("op%0d_busw a=%h b=%h", code, a, b), BusW, e);
        chk($sformatf("op%0d_zero", code), {31'd0, Zero}, {31'd0, e == 32'd0});
        last_w = e;
    endtask

    task automatic idle_hold();
        @(posedge CLK); #1;
        chk("idle_done", {31'd0, done}, 32'd0);
        chk("idle_hold_busw", BusW, last_w);
    endtask

    // MULA with optional same-cycle acc_clr, a mid-run ADD+acc_clr injection
    // cycle, and an optional asynchronous reset cycle (0 disables each).
    task automatic mula(input logic [31:0] a, input logic [31:0] b, input logic clr,
                        input int inject_at, input int reset_at);
        logic [63:0] prod;
        @(negedge CLK);
        start = 1'b1; ALUCtrl = 4'd5; BusA = a; BusB = b; acc_clr = clr;
        @(posedge CLK); #1;
        start = 1'b0; acc_clr = 1'b0;
        ALUCtrl = 4'(($urandom % 4) * 4); BusA = $urandom; BusB = $urandom;
        if (clr) acc_m = 32'd0;
        chk("mula_busy_accept", {31'd0, busy}, 32'd1);
        chk("mula_done_accept", {31'd0, done}, 32'd0);
        for (int i = 1; i <= 32; i++) begin
            if (i == inject_at) begin
                @(negedge CLK);
                start = 1'b1; ALUCtrl = 4'd2; acc_clr = 1'b1;
            end
            if (i == reset_at) begin
                @(negedge CLK);
                #2 Reset_L = 1'b0;
                #1;
                chk("rst_mid_busw", BusW, 32'd0);
                chk("rst_mid_zero", {31'd0, Zero}, 32'd1);
                chk("rst_mid_busy", {31'd0, busy}, 32'd0);
                chk("rst_mid_done", {31'd0, done}, 32'd0);
                acc_m  = 32'd0;
                last_w = 32'd0;
                @(negedge CLK);
                Reset_L = 1'b1;
                idle_hold();
                return;
            end
            @(posedge CLK); #1;
            start = 1'b0; acc_clr = 1'b0;
            if (i < 32) begin
                if (busy !== 1'b1 || done !== 1'b0) begin
                    chk($sformatf("mula_busy_c%0d", i), {31'd0, busy}, 32'd1);
                    chk($sformatf("mula_done_c%0d", i), {31'd0, done}, 32'd0);
                end
            end else begin
                prod  = 64'(a) * 64'(b);
                acc_m = acc_m + prod[31:0];
                chk("mula_done_c32", {31'd0, done}, 32'd1);
                chk("mula_busy_c32", {31'd0, busy}, 32'd0);
                chk($sformatf("mula_busw a=%h b=%h", a, b), BusW, acc_m);
                chk("mula_zero", {31'd0, Zero}, {31'd0, acc_m == 32'd0});
                last_w = acc_m;
            end
        end
    endtask

    initial begin
        checks = 0; fails = 0; acc_m = 32'd0; last_w = 32'd0;
        Reset_L = 1'b0; start = 1'b0; ALUCtrl = 4'd0; BusA = '0; BusB = '0; acc_clr = 1'b0;
        #23;
        chk("reset_busw", BusW, 32'd0);
        chk("reset_zero", {31'd0, Zero}, 32'd1);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        @(negedge CLK);
        Reset_L = 1'b1;

        sop(4'd2, 32'd7, 32'd5);
        chk("add_7_5", BusW, 32'd12);
        idle_hold();
        sop(4'd6, 32'd5, 32'd5);
        chk("sub_5_5_zero", {31'd0, Zero}, 32'd1);
        sop(4'd7, 32'hFFFF_FFFF, 32'd1);
        chk("slt_m1_1", BusW, 32'd1);
        sop(4'd11, 32'hFFFF_FFFF, 32'd1);
        chk("sltu_m1_1", BusW, 32'd0);
        sop(4'd13, 32'd4, 32'h8000_0000);
        chk("sra_4", BusW, 32'hF800_0000);
        sop(4'd14, 32'd0, 32'h0000_1234);
        chk("lui_1234", BusW, 32'h1234_0000);
        sop(4'd15, 32'd9, 32'd9);
        idle_hold();

        mula(32'd3, 32'd4, 1'b0, 0, 0);
        chk("mula_3x4", BusW, 32'd12);
        mula(32'd5, 32'd6, 1'b0, 0, 0);
        chk("mula_5x6_acc", BusW, 32'd42);
        mula(32'hFFFF_FFFF, 32'd2, 1'b1, 0, 0);
        chk("mula_trunc", BusW, 32'hFFFF_FFFE);
        mula(32'd2, 32'd2, 1'b1, 0, 0);
        chk("mula_clr_2x2", BusW, 32'd4);
        idle_hold();

        mula(32'd7, 32'd9, 1'b0, 10, 0);
        chk("mula_inject_result", BusW, 32'd67);
        idle_hold();

        mula(32'd11, 32'd13, 1'b0, 0, 15);
        mula(32'd2, 32'd3, 1'b0, 0, 0);
        chk("mula_after_reset", BusW, 32'd6);

        // Idle acc_clr without start clears the accumulator
        @(negedge CLK);
        acc_clr = 1'b1;
        @(posedge CLK); #1;
        acc_clr = 1'b0;
        chk("idle_clr_done", {31'd0, done}, 32'd0);
        acc_m = 32'd0;
        mula(32'd10, 32'd10, 1'b0, 0, 0);
        chk("mula_after_idle_clr", BusW, 32'd100);

        sop(4'd0, 32'h0000_00F0, 32'h0000_003C);
        chk("b2b_and", BusW, 32'h0000_0030);
        sop(4'd1, 32'h0000_00F0, 32'h0000_003C);
        chk("b2b_or", BusW, 32'h0000_00FC);
        sop(4'd12, 32'd0, 32'd0);
        chk("b2b_nor", BusW, 32'hFFFF_FFFF);
        idle_hold();

        for (int n = 0; n < 40; n++) begin
            logic [3:0] c;
            c = 4'($urandom_range(0, 15));
            if (c == 4'd5) c = 4'd2;
            sop(c, $urandom, (n % 4 == 0) ? 32'($urandom_range(0, 3)) : $urandom);
        end
        for (int n = 0; n < 4; n++) begin
            mula($urandom, $urandom, 1'($urandom_range(0, 1)), 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
